// File: rtl/fifo_burst_reader.sv
// Read-side consumer of the async FIFO: issues bursts of reads, absorbs read latency in a
// 2-entry skid buffer, emits a valid/ready stream framed by m_last. Timeout flush: FIFO_BURST_READER_TIMEOUT_EN.
module fifo_burst_reader #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 8,
  parameter int BURST_LEN  = 4,
  parameter int TIMEOUT    = 16,
  // bit width of FIFO_DEPTH-1, plus one (8 -> 4)
  localparam int CNT_W     = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                  rd_clk,
  input  logic                  rst,
  input  logic                  fifo_empty,
  input  logic [CNT_W-1:0]      fifo_rd_count,
  input  logic [DATA_WIDTH-1:0] fifo_dout,
  output logic                  fifo_rd_en,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last,
  output logic                  busy
);

  if (BURST_LEN < 1 || BURST_LEN > FIFO_DEPTH || TIMEOUT < 1) begin : g_param_check
    $error("fifo_burst_reader: illegal BURST_LEN/TIMEOUT");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1
`ifdef FIFO_BURST_READER_TIMEOUT_EN
    , FLUSH = 2'd2
`endif
  } state_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      rem_q, rem_d;
  logic                  inflight_q, inflight_d;
  logic                  inflight_last_q, inflight_last_d;
  logic [1:0]            buf_cnt_q, buf_cnt_d;
  logic [DATA_WIDTH-1:0] buf_data_q [2];
  logic [DATA_WIDTH-1:0] buf_data_d [2];
  logic                  buf_last_q [2];
  logic                  buf_last_d [2];

  logic                  pop;
  logic                  rd_go;
  logic                  wr_slot;
  logic [2:0]            occ;

`ifdef FIFO_BURST_READER_TIMEOUT_EN
  // bit width of TIMEOUT; the timer only ever reaches TIMEOUT-1
  localparam int TMR_W = $clog2(TIMEOUT + 1);
  logic [TMR_W-1:0]      timer_q, timer_d;
`endif

  assign m_valid = (buf_cnt_q != 2'd0);
  assign m_data  = buf_data_q[0];
  assign m_last  = buf_last_q[0];
  assign busy    = (state_q != IDLE) || inflight_q || (buf_cnt_q != 2'd0);
  assign fifo_rd_en = rd_go;

  // Read issue: never let buffered + in-flight words exceed the two skid slots.
  always_comb begin
    pop   = m_valid & m_ready;
    occ   = {1'b0, buf_cnt_q} + {2'b00, inflight_q} - {2'b00, pop};
    rd_go = (state_q != IDLE) && (rem_q != '0) && !fifo_empty && (occ < 3'd2) && !rst;
  end

  always_comb begin
    inflight_d      = rd_go;
    inflight_last_d = (rem_q == CNT_W'(1));
  end

  // Skid buffer: head in slot 0; a pop shifts, the arriving word lands behind what remains.
  always_comb begin
    buf_data_d = buf_data_q;
    buf_last_d = buf_last_q;
    wr_slot    = (buf_cnt_q == 2'd2) || ((buf_cnt_q == 2'd1) && !pop);
    if (pop) begin
      buf_data_d[0] = buf_data_q[1];
      buf_last_d[0] = buf_last_q[1];
    end
    if (inflight_q) begin
      buf_data_d[wr_slot] = fifo_dout;
      buf_last_d[wr_slot] = inflight_last_q;
    end
    buf_cnt_d = buf_cnt_q + {1'b0, inflight_q} - {1'b0, pop};
  end

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
`ifdef FIFO_BURST_READER_TIMEOUT_EN
    timer_d = timer_q;
`endif
    case (state_q)
      IDLE: begin
        if (fifo_rd_count >= CNT_W'(BURST_LEN)) begin
          state_d = BURST;
          rem_d   = CNT_W'(BURST_LEN);
`ifdef FIFO_BURST_READER_TIMEOUT_EN
          timer_d = '0;
        end else if (fifo_empty) begin
          timer_d = '0;
        end else if (timer_q == TMR_W'(TIMEOUT - 1)) begin
          // an under-reporting count of 0 cannot seed a flush; hold the timer until it catches up
          if (fifo_rd_count != '0) begin
            state_d = FLUSH;
            rem_d   = fifo_rd_count;
            timer_d = '0;
          end
        end else begin
          timer_d = timer_q + TMR_W'(1);
`endif
        end
      end
      default: begin
        if (rd_go) begin
          rem_d = rem_q - CNT_W'(1);
          if (rem_q == CNT_W'(1)) begin
            state_d = IDLE;
          end
        end
      end
    endcase
  end

  always_ff @(posedge rd_clk or posedge rst) begin
    if (rst) begin
      state_q         <= IDLE;
      rem_q           <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      buf_cnt_q       <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        buf_data_q[i] <= '0;
        buf_last_q[i] <= 1'b0;
      end
    end else begin
      state_q         <= state_d;
      rem_q           <= rem_d;
      inflight_q      <= inflight_d;
      inflight_last_q <= inflight_last_d;
      buf_cnt_q       <= buf_cnt_d;
      for (int i = 0; i < 2; i++) begin
        buf_data_q[i] <= buf_data_d[i];
        buf_last_q[i] <= buf_last_d[i];
      end
    end
  end

`ifdef FIFO_BURST_READER_TIMEOUT_EN
  always_ff @(posedge rd_clk or posedge rst) begin
    if (rst) begin
      timer_q <= '0;
    end else begin
      timer_q <= timer_d;
    end
  end
`endif

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Bench for fifo_burst_reader: FIFO model, per-cycle reference model of the framed stream,
// a cycle table for a full burst, and directed corner sequences.
module tb_fifo_burst_reader;

  localparam int BL = 4;
  localparam int TO = 16;

  logic       clk;
  logic       rst;
  logic       fifo_empty;
  logic [3:0] fifo_rd_count;
  logic [7:0] fifo_dout;
  logic       fifo_rd_en;
  logic       m_valid;
  logic       m_ready;
  logic [7:0] m_data;
  logic       m_last;
  logic       busy;

  fifo_burst_reader #(
    .DATA_WIDTH(8), .FIFO_DEPTH(8), .BURST_LEN(BL), .TIMEOUT(TO)
  ) dut (
    .rd_clk(clk), .rst(rst), .fifo_empty(fifo_empty), .fifo_rd_count(fifo_rd_count),
    .fifo_dout(fifo_dout), .fifo_rd_en(fifo_rd_en), .m_valid(m_valid), .m_ready(m_ready),
    .m_data(m_data), .m_last(m_last), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed { logic [7:0] d; logic l; } beat_t;
  typedef struct { logic rd; logic v; logic [7:0] d; logic l; logic bsy; } vec_t;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] fq[$];          // FIFO contents
  beat_t      vis[$];         // words the stream should be presenting, head first
  beat_t      arriving[$];    // words read last cycle, not yet presentable
  int         want;           // words still to request in the current burst/flush (0 = idle)
  int         idle_wait;      // cycles of non-empty idling
  logic [7:0] got_d[$];
  logic       got_l[$];
  logic       s_rd, s_valid, s_last, s_busy;
  logic [7:0] s_data;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  function automatic void drive_flags();
    fifo_empty    = (fq.size() == 0);
    fifo_rd_count = 4'(fq.size());
  endfunction

  function automatic void push(logic [7:0] d);
    if (fq.size() < 8) fq.push_back(d);
    drive_flags();
  endfunction

  function automatic void check_stream(string tag, logic [7:0] ed[$], logic el[$]);
    chk({tag, "_len"}, 32'(got_d.size()), 32'(ed.size()));
    for (int i = 0; i < ed.size() && i < got_d.size(); i++) begin
      chk({tag, "_data"}, 32'(got_d[i]), 32'(ed[i]));
      chk({tag, "_last"}, 32'(got_l[i]), 32'(el[i]));
    end
  endfunction

  // One clock cycle: sample at the falling edge, check against the model, advance the model,
  // then update the FIFO just after the rising edge.
  task automatic tick();
    bit    e_pop, e_rd;
    int    occ, cnt;
    beat_t b;
    @(negedge clk);
    s_rd = fifo_rd_en; s_valid = m_valid; s_data = m_data; s_last = m_last; s_busy = busy;
    e_pop = (vis.size() > 0) && m_ready;
    occ   = vis.size() + arriving.size() - (e_pop ? 1 : 0);
    e_rd  = (want > 0) && (fq.size() > 0) && (occ < 2);
    chk("rd_en", 32'(s_rd), 32'(e_rd));
    chk("m_valid", 32'(s_valid), 32'(vis.size() > 0));
    if (vis.size() > 0) begin
      chk("m_data", 32'(s_data), 32'(vis[0].d));
      chk("m_last", 32'(s_last), 32'(vis[0].l));
    end
    chk("busy", 32'(s_busy), 32'((want > 0) || (arriving.size() > 0) || (vis.size() > 0)));
    if (s_valid && m_ready) begin
      got_d.push_back(s_data);
      got_l.push_back(s_last);
    end
    cnt = fq.size();
    if (e_pop) void'(vis.pop_front());
    while (arriving.size() > 0) vis.push_back(arriving.pop_front());
    if (want > 0) begin
      if (e_rd) begin
        b.d = fq[0];
        b.l = (want == 1);
        arriving.push_back(b);
        want--;
      end
    end else if (cnt >= BL) begin
      want = BL;
      idle_wait = 0;
    end
`ifdef FIFO_BURST_READER_TIMEOUT_EN
    else if (cnt == 0) idle_wait = 0;
    else if (idle_wait == TO - 1) begin
      want = cnt;
      idle_wait = 0;
    end else idle_wait++;
`endif
    @(posedge clk);
    #1;
    if (s_rd && fq.size() > 0) fifo_dout = fq.pop_front();
    drive_flags();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk("rst_rd_en", 32'(fifo_rd_en), 32'd0);
    chk("rst_m_valid", 32'(m_valid), 32'd0);
    chk("rst_m_data", 32'(m_data), 32'd0);
    chk("rst_m_last", 32'(m_last), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    want = 0; idle_wait = 0;
    vis.delete(); arriving.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    got_d.delete(); got_l.delete();
  endtask

  vec_t       tbl[8];
  logic [7:0] ed[$];
  logic       el[$];
  int         first;

  initial begin
    fifo_dout = 8'h00;
    m_ready   = 1'b1;
    want = 0; idle_wait = 0;
    drive_flags();
    do_reset();
    tick(); tick();
    chk("idle_rd_en", 32'(s_rd), 32'd0);

    // Full burst: exact cycle-by-cycle expectations
    tbl[0] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
    tbl[1] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b1};
    tbl[2] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b1};
    tbl[3] = '{1'b1, 1'b1, 8'h11, 1'b0, 1'b1};
    tbl[4] = '{1'b1, 1'b1, 8'h14, 1'b0, 1'b1};
    tbl[5] = '{1'b0, 1'b1, 8'h20, 1'b0, 1'b1};
    tbl[6] = '{1'b0, 1'b1, 8'h21, 1'b1, 1'b1};
    tbl[7] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
    push(8'h11); push(8'h14); push(8'h20); push(8'h21);
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("tbl_rd_en", 32'(s_rd), 32'(tbl[i].rd));
      chk("tbl_valid", 32'(s_valid), 32'(tbl[i].v));
      if (tbl[i].v) begin
        chk("tbl_data", 32'(s_data), 32'(tbl[i].d));
        chk("tbl_last", 32'(s_last), 32'(tbl[i].l));
      end
      chk("tbl_busy", 32'(s_busy), 32'(tbl[i].bsy));
    end

    // Backpressure: stall after the first beat
    do_reset();
    m_ready = 1'b1;
    for (int i = 0; i < 4; i++) push(8'hA0 + 8'(i));
    repeat (4) tick();
    m_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("bp_rd_en", 32'(s_rd), 32'd0);
      chk("bp_valid", 32'(s_valid), 32'd1);
      chk("bp_data", 32'(s_data), 32'hA1);
      chk("bp_last", 32'(s_last), 32'd0);
    end
    m_ready = 1'b1;
    repeat (8) tick();
    ed = '{8'hA0, 8'hA1, 8'hA2, 8'hA3}; el = '{1'b0, 1'b0, 1'b0, 1'b1};
    check_stream("bp", ed, el);

    // Burst plus partial remainder
    do_reset();
    for (int i = 1; i <= 6; i++) push(8'(i));
    repeat (40) tick();
`ifdef FIFO_BURST_READER_TIMEOUT_EN
    ed = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
    el = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    check_stream("flush", ed, el);
`else
    ed = '{8'h01, 8'h02, 8'h03, 8'h04}; el = '{1'b0, 1'b0, 1'b0, 1'b1};
    check_stream("noflush", ed, el);
    chk("noflush_left", 32'(fq.size()), 32'd2);
    push(8'h07); push(8'h08);
    repeat (12) tick();
    ed = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    el = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    check_stream("noflush2", ed, el);
`endif

    // Timeout edge: 3 words never form a burst
    do_reset();
    push(8'h31); push(8'h32); push(8'h33);
    first = -1;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (s_rd && first < 0) first = i;
    end
`ifdef FIFO_BURST_READER_TIMEOUT_EN
    chk("to_first_rd", 32'(first), 32'd16);
    ed = '{8'h31, 8'h32, 8'h33}; el = '{1'b0, 1'b0, 1'b1};
    check_stream("to", ed, el);
`else
    chk("to_first_rd", 32'(first), 32'hFFFFFFFF);
    chk("to_left", 32'(fq.size()), 32'd3);
    fq.delete(); drive_flags();
`endif

    // Reset in the middle of a burst; the words still in the FIFO survive
    do_reset();
    for (int i = 0; i < 6; i++) push(8'hC0 + 8'(i));
    for (int i = 0; i < 20 && got_d.size() < 2; i++) tick();
    chk("mid_accepted", 32'(got_d.size()), 32'd2);
    do_reset();
    chk("mid_left", 32'(fq.size()), 32'd2);
    repeat (30) tick();
`ifdef FIFO_BURST_READER_TIMEOUT_EN
    ed = '{8'hC4, 8'hC5}; el = '{1'b0, 1'b1};
    check_stream("mid", ed, el);
`else
    chk("mid_none", 32'(got_d.size()), 32'd0);
`endif

    // Randomized traffic against the model
    do_reset();
    fq.delete(); drive_flags();
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 2) == 0) push(8'($urandom));
      m_ready = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 399) == 0) do_reset();
      tick();
    end
    m_ready = 1'b1;
    repeat (60) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fifo_burst_reader.md
Name: fifo_burst_reader

Overview:
- Read-side consumer for the team's asynchronous FIFO. Runs in the FIFO read clock domain.
- Drives the FIFO read port and absorbs its 1-cycle read latency in a 2-entry skid buffer.
- Repackages words as a valid/ready stream with m_last framing: full bursts of BURST_LEN words, plus timeout-driven partial flushes.
- Sits between the FIFO read port and a downstream packet consumer.

Parameters:
- DATA_WIDTH, 8, word width; must equal the FIFO data width.
- FIFO_DEPTH, 8, FIFO depth. Sets CNT_W = clogb2(FIFO_DEPTH-1)+1, with clogb2 as the team's standard bit-width function (FIFO_DEPTH=8 gives CNT_W=4).
- BURST_LEN, 4, words per full burst; legal range 1..FIFO_DEPTH.
- TIMEOUT, 16, rd_clk cycles of a non-empty-but-short FIFO before a partial flush; must be ≥1.

Ports:
- rd_clk  in  1  read-domain clock; all logic on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- fifo_empty  in  1  FIFO empty flag.
- fifo_rd_count  in  CNT_W  FIFO read-side occupancy; may under-report, never over-reports.
- fifo_dout  in  DATA_WIDTH  FIFO read data; valid the cycle after fifo_rd_en.
- fifo_rd_en  out  1  FIFO read strobe.
- m_valid  out  1  stream valid.
- m_ready  in  1  stream ready.
- m_data  out  DATA_WIDTH  stream data.
- m_last  out  1  final word of a burst or flush.
- busy  out  1  high when state≠IDLE, or a read is in flight, or the skid buffer is non-empty.

Behaviour:

Reset:
- rst high drives, asynchronously: m_valid=0, m_data=0, m_last=0, busy=0, state=IDLE, and clears timer, remaining, buffer count, in-flight flag.
- fifo_rd_en is combinational and is 0 while rst is high.
- Reset mid-burst drops in-flight and buffered words. Words still in the FIFO are untouched.

Read pipeline:
- fifo_rd_en high in cycle c → fifo_dout sampled at end of cycle c+1 into the skid buffer.
- m_valid is earliest visible in cycle c+2, so latency fifo_rd_en → m_valid is 2 cycles.
- Each read carries a last tag equal to (remaining==1) at issue time.

Read issue:
- fifo_rd_en = (state is BURST or FLUSH) AND remaining≠0 AND !fifo_empty AND (buf_cnt + inflight − pop) < 2, where pop = m_valid & m_ready.
- This sustains 1 word/cycle when m_ready is held high.
- fifo_rd_en is never high while fifo_empty=1.

Stream rules:
- m_valid=1 holds m_data and m_last stable until the word is accepted (m_ready=1).
- Words are delivered in FIFO order, with no loss and no duplication.
- A pop and a buffer load in the same cycle are both applied.

State machine, IDLE:
- If fifo_rd_count ≥ BURST_LEN: go to BURST, remaining=BURST_LEN, timer=0.
- Else if !fifo_empty: timer increments. When timer==TIMEOUT-1: go to FLUSH, remaining=fifo_rd_count (snapshot), timer=0.
- If fifo_empty: timer=0.
- If BURST_LEN=1, FLUSH is unreachable.

State machine, BURST / FLUSH:
- remaining decrements on each fifo_rd_en.
- fifo_rd_en with remaining==1 returns to IDLE.
- The next burst may start while earlier words still sit in the buffer.

Stalls:
- fifo_empty during BURST or FLUSH stalls reads; state and remaining are held. There is no timeout in these states.

Counter widths:
- remaining is CNT_W bits; timer is clogb2(TIMEOUT) bits.
- Neither counter wraps: both saturate by construction of the transitions.

Optional Feature:
- Macro: FIFO_BURST_READER_TIMEOUT_EN.
- Defined: the IDLE timer and the FLUSH state exist as described above.
- Undefined: no timer and no FLUSH state. Reads start only when fifo_rd_count ≥ BURST_LEN, so partial data waits in the FIFO indefinitely and every m_last closes exactly BURST_LEN words.

Test Plan (defaults; 8-bit data):
- Reset: rst=1 mid-simulation → fifo_rd_en, m_valid, m_data, m_last, busy all 0 within the same cycle. They stay 0 until the FIFO holds data after rst=0.
- Full burst: write 0x11, 0x14, 0x20, 0x21 with m_ready=1 → fifo_rd_en high for exactly 4 consecutive cycles. m_data = 0x11, 0x14, 0x20, 0x21 on consecutive cycles, with m_last=1 only on 0x21.
- Burst plus flush: 6 words 0x01–0x06 → burst 0x01–0x04 with m_last on 0x04. Then fifo_rd_count=2 idles 16 cycles, then flush 0x05, 0x06 with m_last on 0x06. With the macro undefined: 0x05 and 0x06 are not read until 2 more words arrive.
- Backpressure: m_ready=0 for 10 cycles after the first beat of a 4-word burst → m_data and m_last stable throughout. fifo_rd_en stops once buffer plus in-flight reaches 2. After m_ready=1 the remaining words arrive in order, no duplicates, and m_last appears once.
- Timeout edge: 3 words with the macro defined → no fifo_rd_en for 15 cycles of non-empty IDLE, FLUSH on the 16th. 3 beats follow, m_last on the third, remaining snapshot=3.
- Reset mid-burst: assert rst after 2 of 4 beats are accepted → outputs clear. After release, the 2 words left in the FIFO go out via flush after 16 cycles (macro defined), with m_last on the second.
